// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fetch_state_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: PC register with deferred redirect target and +4 increment
// load_i    : write target_i into the PC directly
// defer_i   : latch target_i as the pending redirect (fetch in flight)
// capture_i : instruction captured; advance PC to pending target or PC+4
// pc_o      : current PC
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              defer_i,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic              pend_q, pend_d, pend_any;

    // A redirect arriving on the capture edge itself still wins over PC+4
    always_comb begin
        pend_any = defer_i | pend_q;
        tgt_d    = defer_i ? target_i : tgt_q;
        pend_d   = pend_any & ~capture_i;
        pc_d     = load_i ? target_i :
                   capture_i ? (pend_any ? tgt_d : pc_q + ADDR_W'(INSTR_BYTES)) : pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            tgt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR owner running a req/resp handshake to instruction memory
// fetch_req/fetch_done/fetch_busy : control handshake
// pc_write/pc_next                : PC redirect, deferred while a fetch is in flight
// pc_out/fetch_pc/instruction_out : current PC, address of IR, IR
// misaligned                      : fetch refused, PC not word aligned
// imem_*                          : memory request/response channel
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    output logic               fetch_done,
    output logic               fetch_busy,
    input  logic               pc_write,
    input  logic [ADDR_W-1:0]  pc_next,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               misaligned,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata
);
    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  fpc_q, fpc_d;
    logic               capture, start, in_flight;

    fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load_i   (pc_write & ~in_flight),
        .defer_i  (pc_write & in_flight),
        .capture_i(capture),
        .target_i (pc_next),
        .pc_o     (pc_out)
    );

    always_comb begin
        in_flight  = (state_q == REQ) || (state_q == WAIT);
        capture    = imem_rvalid && (state_q == WAIT || (state_q == REQ && imem_ready));
        // pc_write in IDLE takes precedence and drops the fetch request
        start      = (state_q == IDLE) && fetch_req && !pc_write;
        misaligned = start && (pc_out[1:0] != 2'b00);
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = (start && !misaligned) ? REQ : IDLE;
            REQ:     state_d = imem_ready ? (imem_rvalid ? DONE : WAIT) : REQ;
            WAIT:    state_d = imem_rvalid ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
        ir_d       = capture ? imem_rdata : ir_q;
        fpc_d      = capture ? pc_out : fpc_q;
        imem_req   = state_q == REQ;
        imem_addr  = pc_out;
        fetch_done = state_q == DONE;
        fetch_busy = state_q != IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            fpc_q   <= fpc_d;
        end
    end

    assign instruction_out = ir_q;
    assign fetch_pc        = fpc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        clk = 0, reset = 1;
    logic        fetch_req = 0, pc_write = 0, imem_ready = 0, imem_rvalid = 0;
    logic [63:0] pc_next = 0;
    logic [31:0] imem_rdata = 0;
    logic        fetch_done, fetch_busy, misaligned, imem_req;
    logic [63:0] pc_out, fetch_pc, imem_addr;
    logic [31:0] instruction_out;
    int          total = 0, bad = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_done(fetch_done),
        .fetch_busy(fetch_busy), .pc_write(pc_write), .pc_next(pc_next), .pc_out(pc_out),
        .fetch_pc(fetch_pc), .instruction_out(instruction_out), .misaligned(misaligned),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2;
        chk("rst_pc", pc_out, 64'h0);
        chk("rst_fpc", fetch_pc, 64'h0);
        chk("rst_ir", 64'(instruction_out), 64'h0);
        chk("rst_bits", {60'h0, fetch_done, fetch_busy, misaligned, imem_req}, 64'h0);
        cyc();
        reset = 0;
        cyc();
        // zero-wait fetch
        imem_ready = 1; imem_rvalid = 1; imem_rdata = 32'h00A00093;
        fetch_req = 1;
        #1 chk("t1_idle_req", 64'(imem_req), 64'h0);
        cyc();
        fetch_req = 0;
        chk("t1_req", 64'(imem_req), 64'h1);
        chk("t1_addr", imem_addr, 64'h0);
        chk("t1_busy", 64'(fetch_busy), 64'h1);
        cyc();
        chk("t1_done", 64'(fetch_done), 64'h1);
        chk("t1_ir", 64'(instruction_out), 64'h00A00093);
        chk("t1_fpc", fetch_pc, 64'h0);
        chk("t1_pc", pc_out, 64'h4);
        cyc();
        chk("t1_done_off", 64'(fetch_done), 64'h0);
        chk("t1_idle", 64'(fetch_busy), 64'h0);
        // delayed ready and response
        imem_ready = 0; imem_rvalid = 0;
        fetch_req = 1;
        cyc();
        fetch_req = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) imem_ready = 1;
            #1 chk("t2_req_hold", {63'h0, imem_req}, 64'h1);
            chk("t2_addr_hold", imem_addr, 64'h4);
            chk("t2_no_done", 64'(fetch_done), 64'h0);
            cyc();
        end
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin imem_rvalid = 1; imem_rdata = 32'h12345678; end
            #1 chk("t2_wait_noreq", 64'(imem_req), 64'h0);
            chk("t2_wait_nodone", 64'(fetch_done), 64'h0);
            cyc();
        end
        imem_rvalid = 0;
        chk("t2_done", 64'(fetch_done), 64'h1);
        chk("t2_ir", 64'(instruction_out), 64'h12345678);
        chk("t2_fpc", fetch_pc, 64'h4);
        chk("t2_pc", pc_out, 64'h8);
        cyc();
        chk("t2_done_once", 64'(fetch_done), 64'h0);
        // redirect during WAIT
        imem_ready = 1;
        fetch_req = 1;
        cyc();
        fetch_req = 0;
        cyc();
        imem_ready = 0;
        chk("t3_wait", {62'h0, fetch_busy, imem_req}, 64'h2);
        pc_write = 1; pc_next = 64'h100;
        cyc();
        pc_write = 0;
        chk("t3_pc_deferred", pc_out, 64'h8);
        imem_rvalid = 1; imem_rdata = 32'hCAFEF00D;
        cyc();
        imem_rvalid = 0;
        chk("t3_done", 64'(fetch_done), 64'h1);
        chk("t3_fpc", fetch_pc, 64'h8);
        chk("t3_pc", pc_out, 64'h100);
        cyc();
        imem_ready = 1; imem_rvalid = 1; imem_rdata = 32'h00000013;
        fetch_req = 1;
        cyc();
        fetch_req = 0;
        chk("t3_next_addr", imem_addr, 64'h100);
        cyc();
        chk("t3_next_pc", pc_out, 64'h104);
        cyc();
        // misaligned
        pc_write = 1; pc_next = 64'h102;
        cyc();
        pc_write = 0;
        chk("t4_pc", pc_out, 64'h102);
        fetch_req = 1;
        #1 chk("t4_mis", 64'(misaligned), 64'h1);
        chk("t4_noreq", 64'(imem_req), 64'h0);
        cyc();
        fetch_req = 0;
        #1 chk("t4_mis_off", 64'(misaligned), 64'h0);
        chk("t4_idle", {62'h0, fetch_busy, imem_req}, 64'h0);
        // wrap
        pc_write = 1; pc_next = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        pc_write = 0;
        fetch_req = 1;
        cyc();
        fetch_req = 0;
        chk("t5_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        chk("t5_done", 64'(fetch_done), 64'h1);
        chk("t5_fpc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc", pc_out, 64'h0);
        cyc();
        // reset during WAIT, orphaned response afterwards
        imem_rvalid = 0; imem_rdata = 32'hDEADBEEF;
        fetch_req = 1;
        cyc();
        fetch_req = 0;
        cyc();
        imem_ready = 0;
        chk("t6_wait", 64'(fetch_busy), 64'h1);
        reset = 1;
        #1 chk("t6_rst_busy", 64'(fetch_busy), 64'h0);
        chk("t6_rst_pc", pc_out, 64'h0);
        chk("t6_rst_ir", 64'(instruction_out), 64'h0);
        cyc();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 2);
            #1 chk("t6_no_done", 64'(fetch_done), 64'h0);
            chk("t6_ir", 64'(instruction_out), 64'h0);
            chk("t6_idle", {62'h0, fetch_busy, imem_req}, 64'h0);
            cyc();
        end
        chk("t6_pc", pc_out, 64'h0);
        chk("t6_fpc", fetch_pc, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
